// File: rtl/dcache_miss_ctrl_pkg.sv
// ============================================================================
// Module   : dcache_miss_ctrl_pkg
// Brief    : Shared encodings for the data-cache miss controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_miss_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVICT  = 2'd1,
        FETCH  = 2'd2,
        RESUME = 2'd3
    } state_t;

    localparam logic ADDR_SEL_VICTIM = 1'b0;
    localparam logic ADDR_SEL_REQ    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dcache_miss_ctrl_if.sv
// ============================================================================
// Module   : dcache_miss_ctrl_if
// Brief    : Pipeline/memory handshake bundle of the miss controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_miss_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             mem_rd_i;
    logic             mem_wr_i;
    logic             hit_i;
    logic             dirty_i;
    logic             mem_ack_i;
    logic             halt_o;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             addr_sel_o;
    logic             refill_we_o;
    logic [CNT_W-1:0] stall_cnt_o;

    // Controller side
    modport slave (
        input  mem_rd_i, mem_wr_i, hit_i, dirty_i, mem_ack_i,
        output halt_o, mem_req_o, mem_we_o, addr_sel_o, refill_we_o, stall_cnt_o
    );

    // Pipeline / memory side
    modport master (
        output mem_rd_i, mem_wr_i, hit_i, dirty_i, mem_ack_i,
        input  halt_o, mem_req_o, mem_we_o, addr_sel_o, refill_we_o, stall_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/dcache_miss_ctrl_stall_counter.sv
// ============================================================================
// Module   : stall_counter
// Brief    : Saturating up-counter with enable, cleared by reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_counter #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             en_i,
    output logic      [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (en_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
// ============================================================================
// Module   : dcache_miss_ctrl
// Brief    : D-cache miss sequencer: halts the pipeline, writes back a dirty
//            victim, refills the line, then releases the pipeline.
//            Optional stall-cycle counter under DCACHE_STALL_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_miss_ctrl
    import dcache_miss_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    dcache_miss_ctrl_if.slave bus
);

    state_t           r_state;
    state_t           w_next;
    logic             w_miss;
    logic             w_halt;
    logic             w_req;
    logic             w_we;
    logic             w_sel;
    logic             w_refill;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_miss = (bus.mem_rd_i | bus.mem_wr_i) & ~bus.hit_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_halt   = 1'b0;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_sel    = ADDR_SEL_VICTIM;
        w_refill = 1'b0;
        case (r_state)
            IDLE: begin
                // Halt combinationally so the missing access never advances
                w_halt = w_miss;
                if (w_miss) begin
                    w_next = bus.dirty_i ? EVICT : FETCH;
                end
            end
            EVICT: begin
                w_halt = 1'b1;
                w_req  = 1'b1;
                w_we   = 1'b1;
                w_sel  = ADDR_SEL_VICTIM;
                if (bus.mem_ack_i) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                w_halt   = 1'b1;
                w_req    = 1'b1;
                w_sel    = ADDR_SEL_REQ;
                w_refill = bus.mem_ack_i;
                if (bus.mem_ack_i) begin
                    w_next = RESUME;
                end
            end
            RESUME: begin
                w_halt = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Reset gating keeps halt low even if the pipeline presents a miss in reset
    assign bus.halt_o      = w_halt & rst_i;
    assign bus.mem_req_o   = w_req;
    assign bus.mem_we_o    = w_we;
    assign bus.addr_sel_o  = w_sel;
    assign bus.refill_we_o = w_refill;

`ifdef DCACHE_STALL_CNT_EN
    stall_counter #(
        .WIDTH (CNT_W)
    ) u_stall_counter (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (bus.halt_o),
        .cnt_o (w_stall_cnt)
    );
`else
    assign w_stall_cnt = '0;
`endif

    assign bus.stall_cnt_o = w_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
// ============================================================================
// Module   : tb_dcache_miss_ctrl
// Brief    : Randomized scoreboard bench for dcache_miss_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_miss_ctrl;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic             halt;
        logic             req;
        logic             we;
        logic             sel;
        logic             refill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    dcache_miss_ctrl_if #(.CNT_W(CNT_W)) bus ();

    dcache_miss_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   halt_cycles = 0;   // halt cycles since last reset
    int   cyc = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Counter value visible in a cycle = halt cycles before it, saturated
    function automatic logic [CNT_W-1:0] cnt_exp(input int n);
`ifdef DCACHE_STALL_CNT_EN
        int maxv = (1 << CNT_W) - 1;
        return (n > maxv) ? CNT_W'(maxv) : CNT_W'(n);
`else
        return '0;
`endif
    endfunction

    function automatic exp_t mk(input logic h, r, w, s, f);
        exp_t e;
        e.halt = h; e.req = r; e.we = w; e.sel = s; e.refill = f;
        e.cnt  = cnt_exp(halt_cycles);
        return e;
    endfunction

    task automatic drive(input logic rd, wr, hit, dirty, ack, input exp_t e);
        @(posedge clk_i);
        #1;
        bus.mem_rd_i  = rd;
        bus.mem_wr_i  = wr;
        bus.hit_i     = hit;
        bus.dirty_i   = dirty;
        bus.mem_ack_i = ack;
        exp_q.push_back(e);
        if (e.halt) halt_cycles++;
    endtask

    // Whole miss sequence built from the timing rules
    task automatic do_miss(input logic dirty, input int ke, input int k);
        logic [1:0] op = 2'($urandom_range(1, 3));
        drive(op[0], op[1], 1'b0, dirty, rb(), mk(1, 0, 0, 0, 0));
        if (dirty)
            for (int i = 0; i <= ke; i++)
                drive(rb(), rb(), rb(), rb(), (i == ke), mk(1, 1, 1, 0, 0));
        for (int j = 0; j <= k; j++)
            drive(rb(), rb(), rb(), rb(), (j == k), mk(1, 1, 0, 1, (j == k)));
        drive(rb(), rb(), rb(), rb(), rb(), mk(1, 0, 0, 0, 0));
    endtask

    task automatic do_hit();
        logic [1:0] op = 2'($urandom_range(1, 3));
        drive(op[0], op[1], 1'b1, rb(), rb(), mk(0, 0, 0, 0, 0));
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, rb(), rb(), rb(), mk(0, 0, 0, 0, 0));
    endtask

    task automatic check_zero(input string name);
        logic [5+CNT_W-1:0] act;
        act = {bus.halt_o, bus.mem_req_o, bus.mem_we_o, bus.addr_sel_o,
               bus.refill_we_o, bus.stall_cnt_o};
        checks++;
        if (act !== '0) begin
            failures++;
            $display("FAIL %s: got %b required all zero", name, act);
        end
    endtask

    // Monitor: outputs are presented every cycle, compared mid-cycle
    always @(negedge clk_i) begin
        exp_t e;
        exp_t a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.halt = bus.halt_o;     a.req = bus.mem_req_o;
            a.we   = bus.mem_we_o;   a.sel = bus.addr_sel_o;
            a.refill = bus.refill_we_o; a.cnt = bus.stall_cnt_o;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL outputs @cyc %0d: got halt=%b req=%b we=%b sel=%b refill=%b cnt=%0d required halt=%b req=%b we=%b sel=%b refill=%b cnt=%0d",
                         cyc, a.halt, a.req, a.we, a.sel, a.refill, a.cnt,
                         e.halt, e.req, e.we, e.sel, e.refill, e.cnt);
            end
        end
    end

    initial begin
        bus.mem_rd_i = 1'b1; bus.mem_wr_i = 1'b0; bus.hit_i = 1'b0;
        bus.dirty_i = 1'b0;  bus.mem_ack_i = 1'b0;
        #2;
        check_zero("reset_state");
        repeat (2) @(posedge clk_i);
        #1;
        check_zero("reset_hold");
        bus.mem_rd_i = 1'b0;
        #1 rst_i = 1'b1;

        for (int i = 0; i < 10; i++) do_hit();
        do_idle();
        do_miss(1'b0, 0, 3);
        do_hit();
        do_miss(1'b1, 2, 2);
        do_hit();
        do_miss(1'b1, 0, 0);
        do_miss(1'b0, 0, 0);
        do_idle();
        for (int i = 0; i < 3; i++) do_miss(1'b0, 0, 2);
        do_miss(1'b0, 1, 1);

        // Reset in the second FETCH cycle, with a miss still presented
        do_idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 0, 0, 0, 0));
        drive(rb(), rb(), rb(), rb(), 1'b0, mk(1, 1, 0, 1, 0));
        drive(rb(), rb(), rb(), rb(), 1'b0, mk(1, 1, 0, 1, 0));
        void'(exp_q.pop_back());
        bus.mem_rd_i = 1'b1; bus.hit_i = 1'b0;
        #2 rst_i = 1'b0;
        #1 check_zero("reset_async");
        @(negedge clk_i);
        check_zero("reset_mid_cycle");
        @(posedge clk_i);
        #1 check_zero("reset_after_edge");
        bus.mem_rd_i = 1'b0; bus.mem_wr_i = 1'b0; bus.mem_ack_i = 1'b0;
        halt_cycles = 0;
        #1 rst_i = 1'b1;
        do_miss(1'b0, 0, 1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: do_idle();
                1: do_hit();
                2: do_miss(1'b0, 0, $urandom_range(0, 4));
                default: do_miss(1'b1, $urandom_range(0, 4), $urandom_range(0, 4));
            endcase
        end

        do_idle();
        repeat (3) @(negedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dcache_miss_ctrl.md
# dcache_miss_ctrl

Miss-handling controller for the data cache in the MEM stage of the 5-stage pipeline. On a load/store miss, it freezes every pipeline register through the shared halt line. It then sequences the off-chip memory transfers: optional dirty write-back, then line fetch. After the refilled line has settled, it releases the pipeline so the stalled access replays and hits.

## Interface
- CNT_W, 32, width of the stall-cycle counter
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- mem_rd_i  in  1  EX/MEM stage issues a load this cycle
- mem_wr_i  in  1  EX/MEM stage issues a store this cycle
- hit_i  in  1  tag compare result for the current access (valid when mem_rd_i|mem_wr_i)
- dirty_i  in  1  victim line dirty bit for the current index
- mem_ack_i  in  1  off-chip memory one-cycle completion pulse
- halt_o  out  1  freeze all pipeline registers (drives halt_i of IFID/IDEX/EXMEM/MEMWB)
- mem_req_o  out  1  off-chip transaction request, level
- mem_we_o  out  1  1 = write-back transaction, 0 = fetch
- addr_sel_o  out  1  0 = victim address {tag,index}, 1 = request address
- refill_we_o  out  1  write fetched line into cache data/tag arrays, clear dirty
- stall_cnt_o  out  CNT_W  total halt cycles since reset

## Operation
- States: IDLE, EVICT, FETCH, RESUME.
- miss = (mem_rd_i | mem_wr_i) & ~hit_i.
- IDLE:
  - miss & dirty_i -> EVICT.
  - miss & ~dirty_i -> FETCH.
  - Otherwise stay.
- EVICT: mem_req_o=1, mem_we_o=1, addr_sel_o=0. mem_ack_i -> FETCH.
- FETCH: mem_req_o=1, mem_we_o=0, addr_sel_o=1. mem_ack_i -> RESUME.
- RESUME: one bubble cycle with no request. Always -> IDLE.
- halt_o = (IDLE & miss) | EVICT | FETCH | RESUME. The IDLE term is combinational so that the missing access is never captured downstream.
- refill_we_o = FETCH & mem_ack_i, combinational. The cache samples the memory data in the ack cycle.
- mem_we_o and addr_sel_o are 0 whenever mem_req_o=0.
- mem_ack_i in IDLE or RESUME is ignored, with no state change.
- A transaction ends in its ack cycle. EVICT->FETCH keeps mem_req_o high, and memory treats the cycle after an ack as a new transaction.
- Inputs mem_rd_i, mem_wr_i, hit_i and dirty_i are don't-care outside IDLE; the pipeline is frozen.
- Reset, including mid-transfer: state=IDLE, and all outputs 0 while rst_i=0. An outstanding transfer is abandoned; off-chip memory shares rst_i.

## Timing
- Clean miss detected at cycle 0, ack at cycle 1+k (k>=0):
  - halt_o high for cycles 0..2+k, i.e. k+3 cycles.
  - Replayed access is evaluated in IDLE at cycle 3+k.
- Dirty miss: add (ke+1) cycles, where ke = eviction ack delay.
- Hit: zero added latency, halt_o=0.
- Back-to-back misses: each replay that hits releases the pipeline. A new miss in the next instruction starts a fresh sequence with no extra gap.
- Outputs other than halt_o and refill_we_o are pure functions of the registered state.

## Configuration
- DCACHE_STALL_CNT_EN defined: stall_cnt_o increments by 1 on every cycle with halt_o=1, saturates at all-ones, and clears on reset.
- DCACHE_STALL_CNT_EN undefined: the counter logic is omitted, and stall_cnt_o is tied to 0 with the port retained.

## Structure
- Shared package: state encoding (IDLE=2'd0, EVICT=2'd1, FETCH=2'd2, RESUME=2'd3) and ADDR_SEL_VICTIM=1'b0 / ADDR_SEL_REQ=1'b1.
- One sub-module: stall_counter, a parameterized saturating counter with enable. It is instantiated only under DCACHE_STALL_CNT_EN.

## Test plan
- Hit path: mem_rd_i=1, hit_i=1 for 10 cycles -> halt_o=0, mem_req_o=0, state IDLE throughout.
- Clean miss:
  - Stimulus: mem_rd_i=1, hit_i=0, dirty_i=0 at cycle 0; mem_ack_i at cycle 4; hit_i=1 from cycle 5.
  - Response: halt_o high cycles 0-5; mem_req_o=1, mem_we_o=0, addr_sel_o=1 in cycles 1-4; refill_we_o=1 only in cycle 4; halt_o=0 at cycle 6.
- Dirty miss:
  - Stimulus: mem_wr_i=1, hit_i=0, dirty_i=1; acks at cycles 3 and 6.
  - Response: mem_we_o=1, addr_sel_o=0 in cycles 1-3; mem_we_o=0, addr_sel_o=1 in cycles 4-6; halt_o high cycles 0-7.
- Spurious ack: mem_ack_i pulse while IDLE with no access, and during RESUME -> no state change, refill_we_o=0.
- Reset mid-FETCH: rst_i low asynchronously in cycle 2 of FETCH -> all outputs 0 immediately; IDLE after release; the next miss restarts the sequence normally.
- Counter, with DCACHE_STALL_CNT_EN and CNT_W=4:
  - 3 clean misses with k=2 -> stall_cnt_o=15.
  - Further misses -> stall_cnt_o holds at 15.
  - Macro undefined -> stall_cnt_o=0 throughout.
